// File: rtl/img_pkg.sv
// Shared constants for the image RAM and the engines that share it.
// Also holds the requester IDs used to wire engines onto arbiter ports.
package img_pkg;

  localparam int X_MAX     = 160;
  localparam int Y_MAX     = 120;
  localparam int ADDR_SZ   = 15;
  localparam int COL_SZ    = 3;
  localparam int MEM_DEPTH = X_MAX * Y_MAX;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;

  localparam int REQ_SCAN  = 0;
  localparam int REQ_ROWS  = 1;
  localparam int REQ_COLS  = 2;
  localparam int REQ_CLEAN = 3;

  typedef logic [ADDR_SZ-1:0] pix_addr_t;
  typedef logic [COL_SZ-1:0]  pix_col_t;

  // Index width for n requesters; never zero so a single requester still has a pointer.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_mem_arbiter_if.sv
// Requester-side bus of the image RAM arbiter: flattened per-requester
// request/address/data plus grant, read strobes and the shared read data.
interface image_mem_arbiter_if #(
  parameter int NREQ    = img_pkg::NREQ,
  parameter int ADDR_SZ = img_pkg::ADDR_SZ,
  parameter int COL_SZ  = img_pkg::COL_SZ
);

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         wr;
  logic [NREQ*ADDR_SZ-1:0] addr;
  logic [NREQ*COL_SZ-1:0]  wdata;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         rvalid;
  logic [COL_SZ-1:0]       rdata;
  logic                    addr_err;

  modport master (
    output req, wr, addr, wdata,
    input  gnt, rvalid, rdata, addr_err
  );

  modport slave (
    input  req, wr, addr, wdata,
    output gnt, rvalid, rdata, addr_err
  );

endinterface

// File: rtl/image_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from start (mod N), returned as index and one-hot.
module rr_pick
  import img_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  win,
  output logic [PW-1:0] win_idx,
  output logic          valid
);

  always_comb begin
    int cand;
    logic [PW-1:0] ci;
    valid   = 1'b0;
    win_idx = '0;
    cand    = 0;
    ci      = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(start) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      ci = cand[PW-1:0];
      if (!valid && req[ci]) begin
        valid   = 1'b1;
        win_idx = ci;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_win
      assign win[gi] = valid && (win_idx == PW'(gi));
    end
  endgenerate

endmodule

// File: rtl/image_mem_arbiter.sv
// Round-robin, burst-limited owner of the single-port image RAM. The owner's
// address/data are muxed straight onto the RAM; reads come back one cycle later.
module image_mem_arbiter #(
  parameter int NREQ      = img_pkg::NREQ,
  parameter int ADDR_SZ   = img_pkg::ADDR_SZ,
  parameter int COL_SZ    = img_pkg::COL_SZ,
  parameter int MEM_DEPTH = img_pkg::MEM_DEPTH,
  parameter int MAX_BURST = img_pkg::MAX_BURST
) (
  input  logic                clk,
  input  logic                resetn,
  image_mem_arbiter_if.slave  bus,
  output logic [ADDR_SZ-1:0]  mem_addr,
  output logic [COL_SZ-1:0]   mem_data,
  output logic                mem_wren,
  input  logic [COL_SZ-1:0]   mem_q
);
  import img_pkg::*;

  localparam int PW = ptr_w(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWNED = 2'd1;
  localparam logic [1:0] ST_HAND  = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic [PW-1:0]   own_reg, own_next;
  logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [BW-1:0]   burst_cnt_reg, burst_cnt_next, burst_inc;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] rvalid_reg, rvalid_next;
  logic            addr_err_reg, addr_err_next;

  logic [ADDR_SZ-1:0] addr_arr  [NREQ];
  logic [COL_SZ-1:0]  wdata_arr [NREQ];
  logic [NREQ-1:0]    own_oh;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.addr[gi*ADDR_SZ +: ADDR_SZ];
      assign wdata_arr[gi] = bus.wdata[gi*COL_SZ +: COL_SZ];
      assign own_oh[gi]    = (own_reg == PW'(gi));
    end
  endgenerate

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  logic [ADDR_SZ-1:0] own_addr;
  logic [COL_SZ-1:0]  own_wdata;
  logic               own_req, own_wr, in_range, active, access;

  assign own_req   = bus.req[own_reg];
  assign own_wr    = bus.wr[own_reg];
  assign own_addr  = addr_arr[own_reg];
  assign own_wdata = wdata_arr[own_reg];
  assign in_range  = own_addr < ADDR_SZ'(MEM_DEPTH);
  // An out-of-range cycle is still a burst slot; only the RAM side is suppressed.
  assign active    = (state_reg == ST_OWNED) && own_req;
  assign access    = active && in_range;

  assign mem_wren = access && own_wr;
  assign mem_addr = access ? own_addr : '0;
  assign mem_data = access ? own_wdata : '0;

  assign bus.gnt      = gnt_reg;
  assign bus.rvalid   = rvalid_reg;
  assign bus.rdata    = mem_q;
  assign bus.addr_err = addr_err_reg;

  logic [NREQ-1:0] pick_req, pick_win;
  logic [PW-1:0]   pick_start, pick_idx;
  logic            pick_valid;

  // While owned, only the other requesters compete, starting after the owner.
  always_comb begin
    pick_req   = bus.req;
    pick_start = rr_ptr_reg;
    if (state_reg == ST_OWNED) begin
      pick_req   = bus.req & ~own_oh;
      pick_start = next_idx(own_reg);
    end
  end

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req     (pick_req),
    .start   (pick_start),
    .win     (pick_win),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  assign burst_inc = (burst_cnt_reg == BW'(MAX_BURST)) ? burst_cnt_reg
                                                       : burst_cnt_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    own_next       = own_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    gnt_next       = gnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next     = ST_OWNED;
          own_next       = pick_idx;
          gnt_next       = pick_win;
          burst_cnt_next = '0;
        end
      end
      ST_OWNED: begin
        if (!own_req) begin
          rr_ptr_next    = next_idx(own_reg);
          burst_cnt_next = '0;
          if (pick_valid) begin
            own_next = pick_idx;
            gnt_next = pick_win;
          end else begin
            state_next = ST_IDLE;
            gnt_next   = '0;
          end
        end else if (burst_inc == BW'(MAX_BURST)) begin
          burst_cnt_next = '0;
          if (pick_valid) begin
            // Burst spent: hold the winner through one grant-free cycle.
            state_next  = ST_HAND;
            own_next    = pick_idx;
            gnt_next    = '0;
            rr_ptr_next = next_idx(own_reg);
          end
        end else begin
          burst_cnt_next = burst_inc;
        end
      end
      ST_HAND: begin
        state_next     = ST_OWNED;
        gnt_next       = own_oh;
        burst_cnt_next = '0;
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  assign rvalid_next   = (access && !own_wr) ? own_oh : '0;
  assign addr_err_next = active && !in_range;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      own_reg       <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
      gnt_reg       <= '0;
      rvalid_reg    <= '0;
      addr_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      own_reg       <= own_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
      gnt_reg       <= gnt_next;
      rvalid_reg    <= rvalid_next;
      addr_err_reg  <= addr_err_next;
    end
  end

endmodule
